// File: rtl/sr_decode_stage_pkg.sv
// Shared RV32I/RV64I decode constants and the decoded-field bundle for the decode stage.
package sr_decode_stage_pkg;

  localparam logic [6:0] RVOP_OP     = 7'b0110011;
  localparam logic [6:0] RVOP_OPIMM  = 7'b0010011;
  localparam logic [6:0] RVOP_LOAD   = 7'b0000011;
  localparam logic [6:0] RVOP_JALR   = 7'b1100111;
  localparam logic [6:0] RVOP_SYSTEM = 7'b1110011;
  localparam logic [6:0] RVOP_STORE  = 7'b0100011;
  localparam logic [6:0] RVOP_BRANCH = 7'b1100011;
  localparam logic [6:0] RVOP_LUI    = 7'b0110111;
  localparam logic [6:0] RVOP_AUIPC  = 7'b0010111;
  localparam logic [6:0] RVOP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [6:0] f7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [6:0] op;
    logic [2:0] fmt;
    logic       illegal;
  } dec_fields_t;

  function automatic dec_fields_t split_fields(input logic [31:0] instr,
                                               input logic [2:0]  fmt,
                                               input logic        illegal);
    split_fields = '{f7: instr[31:25], rs2: instr[24:20], rs1: instr[19:15],
                     f3: instr[14:12], rd: instr[11:7], op: instr[6:0],
                     fmt: fmt, illegal: illegal};
  endfunction

endpackage

// File: rtl/sr_imm_gen.sv
// Combinational opcode classification and sign-extended immediate selection.
module sr_imm_gen
  import sr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt_c,
  output logic            illegal_c,
  output logic [XLEN-1:0] imm_c
);

  logic [31:0] imm32;

  always_comb begin
    fmt_c     = FMT_ILL;
    illegal_c = 1'b0;
    imm32     = '0;
    case (instr[6:0])
      RVOP_OP:                                         fmt_c = FMT_R;
      RVOP_OPIMM, RVOP_LOAD, RVOP_JALR, RVOP_SYSTEM:   fmt_c = FMT_I;
      RVOP_STORE:                                      fmt_c = FMT_S;
      RVOP_BRANCH:                                     fmt_c = FMT_B;
      RVOP_LUI, RVOP_AUIPC:                            fmt_c = FMT_U;
      RVOP_JAL:                                        fmt_c = FMT_J;
      default:                                         illegal_c = 1'b1;
    endcase
    // R format and illegal opcodes fall through to a zero immediate
    case (fmt_c)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit immediate already carries instr[31] in bit 31, so widening is a plain sign extension
  assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/sr_decode_stage.sv
// Registered decode stage: output register plus optional one-entry skid buffer on a valid/ready link.
module sr_decode_stage
  import sr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_f3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_f7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  logic [2:0]      in_fmt_c;
  logic            in_illegal_c;
  logic [XLEN-1:0] in_imm_c;
  dec_fields_t     in_fields_c;
  logic            in_fire_c;

  logic            out_valid_q;
  dec_fields_t     out_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] out_imm_q;

  logic            skid_valid_q;
  dec_fields_t     skid_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_imm_q;

  sr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr     (in_instr),
    .fmt_c     (in_fmt_c),
    .illegal_c (in_illegal_c),
    .imm_c     (in_imm_c)
  );

  assign in_fields_c = split_fields(in_instr, in_fmt_c, in_illegal_c);

  if (SKID != 0) begin : g_skid
    assign in_ready = !skid_valid_q;
  end else begin : g_noskid
    assign in_ready = !out_valid_q || out_ready;
  end

  assign in_fire_c = in_valid && in_ready;

  // Output slot refills from the skid entry first so ordering is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_pc_q     <= '0;
      out_imm_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_q        <= skid_q;
        out_pc_q     <= skid_pc_q;
        out_imm_q    <= skid_imm_q;
        skid_valid_q <= 1'b0;
      end else if (in_fire_c) begin
        out_valid_q <= 1'b1;
        out_q       <= in_fields_c;
        out_pc_q    <= in_pc;
        out_imm_q   <= in_imm_c;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire_c) begin
      skid_valid_q <= 1'b1;
      skid_q       <= in_fields_c;
      skid_pc_q    <= in_pc;
      skid_imm_q   <= in_imm_c;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_op      = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_f3      = out_q.f3;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_f7      = out_q.f7;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_sr_decode_stage.sv
// Bench for sr_decode_stage: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances checked against a scoreboard.
module tb_sr_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] imm;
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] pc;
  } exp_t;

  localparam int unsigned NVEC = 16;

  vec_t tbl [NVEC];
  exp_t q32 [$];
  exp_t q64 [$];
  int   checks = 0;
  int   errors = 0;
  int   cur32  = 0;
  int   cur64  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_illegal32;
  logic [31:0] in_instr32 = '0, in_pc32 = '0, out_pc32, out_imm32;
  logic [6:0]  out_op32, out_f7_32;
  logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
  logic [2:0]  out_f3_32, out_fmt32;

  logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_illegal64;
  logic [31:0] in_instr64 = '0;
  logic [63:0] in_pc64 = '0, out_pc64, out_imm64;
  logic [6:0]  out_op64, out_f7_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [2:0]  out_f3_64, out_fmt64;

  sr_decode_stage #(.XLEN(32), .SKID(1)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
    .out_op(out_op32), .out_rd(out_rd32), .out_f3(out_f3_32), .out_rs1(out_rs1_32),
    .out_rs2(out_rs2_32), .out_f7(out_f7_32), .out_fmt(out_fmt32), .out_imm(out_imm32),
    .out_illegal(out_illegal32)
  );

  sr_decode_stage #(.XLEN(64), .SKID(0)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
    .out_op(out_op64), .out_rd(out_rd64), .out_f3(out_f3_64), .out_rs1(out_rs1_64),
    .out_rs2(out_rs2_64), .out_f7(out_f7_64), .out_fmt(out_fmt64), .out_imm(out_imm64),
    .out_illegal(out_illegal64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out32(input exp_t e);
    vec_t v;
    v = tbl[e.idx];
    chk($sformatf("fields32[%0d]", e.idx),
        64'({out_f7_32, out_rs2_32, out_rs1_32, out_f3_32, out_rd32, out_op32}), 64'(v.instr));
    chk($sformatf("fmt32[%0d]", e.idx), 64'(out_fmt32), 64'(v.fmt));
    chk($sformatf("ill32[%0d]", e.idx), 64'(out_illegal32), 64'(v.ill));
    chk($sformatf("imm32[%0d]", e.idx), 64'(out_imm32), 64'(v.imm[31:0]));
    chk($sformatf("pc32[%0d]", e.idx), 64'(out_pc32), 64'(e.pc[31:0]));
  endtask

  task automatic check_out64(input exp_t e);
    vec_t v;
    v = tbl[e.idx];
    chk($sformatf("fields64[%0d]", e.idx),
        64'({out_f7_64, out_rs2_64, out_rs1_64, out_f3_64, out_rd64, out_op64}), 64'(v.instr));
    chk($sformatf("fmt64[%0d]", e.idx), 64'(out_fmt64), 64'(v.fmt));
    chk($sformatf("ill64[%0d]", e.idx), 64'(out_illegal64), 64'(v.ill));
    chk($sformatf("imm64[%0d]", e.idx), out_imm64, v.imm);
    chk($sformatf("pc64[%0d]", e.idx), out_pc64, e.pc);
  endtask

  // Scoreboard: sampled mid-cycle, transfers decided here take effect at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid32", 64'(out_valid32), 64'(q32.size() != 0));
      chk("ready32", 64'(in_ready32), 64'(q32.size() < 2));
      if (out_valid32 && q32.size() != 0) check_out32(q32[0]);
      if (flush) q32.delete();
      else begin
        if (out_valid32 && out_ready && q32.size() != 0) void'(q32.pop_front());
        if (in_valid32 && in_ready32) q32.push_back('{cur32, 64'(in_pc32)});
      end

      chk("valid64", 64'(out_valid64), 64'(q64.size() != 0));
      chk("ready64", 64'(in_ready64), 64'(q64.size() == 0 || out_ready));
      if (out_valid64 && q64.size() != 0) check_out64(q64[0]);
      if (flush) q64.delete();
      else begin
        if (out_valid64 && out_ready && q64.size() != 0) void'(q64.pop_front());
        if (in_valid64 && in_ready64) q64.push_back('{cur64, in_pc64});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input int idx);
    in_valid32 = 1'b1;
    in_instr32 = tbl[idx].instr;
    in_pc32    = 32'h1000 + 32'(idx) * 32'd4;
    cur32      = idx;
  endtask

  task automatic drive64(input int idx);
    in_valid64 = 1'b1;
    in_instr64 = tbl[idx].instr;
    in_pc64    = 64'h1_0000_0000 + 64'(idx) * 64'd4;
    cur64      = idx;
  endtask

  initial begin
    tbl[0]  = '{32'hFFF10093, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}; // addi x1,x2,-1
    tbl[1]  = '{32'h00512423, 3'd2, 1'b0, 64'h0000_0000_0000_0008}; // sw x5,8(x2)
    tbl[2]  = '{32'hFE000EE3, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}; // beq x0,x0,-4
    tbl[3]  = '{32'h001000EF, 3'd5, 1'b0, 64'h0000_0000_0000_0800}; // jal x1,2048
    tbl[4]  = '{32'h800000B7, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000}; // lui x1,0x80000
    tbl[5]  = '{32'h00000000, 3'd7, 1'b1, 64'h0};
    tbl[6]  = '{32'h002081B3, 3'd0, 1'b0, 64'h0};                   // add x3,x1,x2
    tbl[7]  = '{32'h00412083, 3'd1, 1'b0, 64'h0000_0000_0000_0004}; // lw x1,4(x2)
    tbl[8]  = '{32'h00008067, 3'd1, 1'b0, 64'h0};                   // jalr x0,0(x1)
    tbl[9]  = '{32'h00000073, 3'd1, 1'b0, 64'h0};                   // ecall
    tbl[10] = '{32'h12345017, 3'd4, 1'b0, 64'h0000_0000_1234_5000}; // auipc x0,0x12345
    tbl[11] = '{32'h0000007F, 3'd7, 1'b1, 64'h0};
    tbl[12] = '{32'hFFFFFFFF, 3'd7, 1'b1, 64'h0};
    tbl[13] = '{32'hFE512E23, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}; // sw x5,-4(x2)
    tbl[14] = '{32'hFFDFF0EF, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}; // jal x1,-4
    tbl[15] = '{32'h002090E3, 3'd3, 1'b0, 64'h0000_0000_0000_0800}; // bne x1,x2,2048

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", 64'(out_valid32), 64'd0);
    chk("rst_ready32", 64'(in_ready32), 64'd1);
    chk("rst_ill32", 64'(out_illegal32), 64'd0);
    chk("rst_data32", 64'({out_pc32, out_imm32}), 64'd0);
    chk("rst_fields32", 64'({out_f7_32, out_rs2_32, out_rs1_32, out_f3_32, out_rd32, out_op32, out_fmt32}), 64'd0);
    chk("rst_valid64", 64'(out_valid64), 64'd0);
    chk("rst_ready64", 64'(in_ready64), 64'd1);
    chk("rst_data64", out_pc64 | out_imm64, 64'd0);
    rst = 1'b0;
    step();

    // Full-rate stream of every table vector through both instances
    out_ready = 1'b1;
    for (int i = 0; i < int'(NVEC); i++) begin
      drive32(i);
      drive64(i);
      step();
    end
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    repeat (2) step();

    // Backpressure on the skid instance: A held, B parked, C stalled
    out_ready = 1'b0;
    drive32(0);
    step();
    drive32(1);
    step();
    drive32(2);
    chk("bp_ready_low", 64'(in_ready32), 64'd0);
    step();
    chk("bp_ready_still_low", 64'(in_ready32), 64'd0);
    chk("bp_hold_instr", 64'({out_f7_32, out_rs2_32, out_rs1_32, out_f3_32, out_rd32, out_op32}),
        64'(tbl[0].instr));
    step();
    out_ready = 1'b1;
    step();
    chk("bp_ready_rise", 64'(in_ready32), 64'd1);
    step();
    in_valid32 = 1'b0;
    repeat (2) step();
    chk("bp_drained", 64'(q32.size()), 64'd0);

    // Flush with a stalled bundle and a new instruction offered
    out_ready = 1'b0;
    drive32(3);
    drive64(3);
    step();
    drive32(4);
    drive64(4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    chk("fl_valid32", 64'(out_valid32), 64'd0);
    chk("fl_valid64", 64'(out_valid64), 64'd0);
    chk("fl_ready32", 64'(in_ready32), 64'd1);
    chk("fl_ready64", 64'(in_ready64), 64'd1);
    repeat (2) step();

    // Flush with the skid entry full must empty it too
    drive32(5);
    step();
    drive32(6);
    step();
    drive32(7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid32 = 1'b0;
    out_ready = 1'b1;
    chk("fl2_valid32", 64'(out_valid32), 64'd0);
    chk("fl2_ready32", 64'(in_ready32), 64'd1);
    repeat (2) step();
    chk("fl2_no_ghost", 64'(out_valid32), 64'd0);

    // Asynchronous reset between edges drops held bundles at once
    out_ready = 1'b0;
    drive32(8);
    drive64(8);
    step();
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    chk("pre_rst_valid32", 64'(out_valid32), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid32", 64'(out_valid32), 64'd0);
    chk("arst_valid64", 64'(out_valid64), 64'd0);
    chk("arst_op32", 64'(out_op32), 64'd0);
    chk("arst_ready32", 64'(in_ready32), 64'd1);
    rst = 1'b0;
    q32.delete();
    q64.delete();
    step();

    // Recovery after reset
    out_ready = 1'b1;
    for (int i = 9; i < 13; i++) begin
      drive32(i);
      drive64(i);
      step();
    end
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    repeat (3) step();
    chk("end_q32", 64'(q32.size()), 64'd0);
    chk("end_q64", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
